seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
- Parametrised, registered ALU for the multicycle CPU datapath.
- Executes the existing single-cycle operation set with one-cycle latency.
- Adds iterative unsigned multiply and unsigned divide (WIDTH cycles each) behind a start/busy/done handshake, with a high-word output and overflow and divide-by-zero flags.
- Sits between the register-file read stage and writeback; the control unit stalls on busy.

Parameters:
- WIDTH, 32, operand/result width; must be a power of 2 and at least 8.
- SHW, log2(WIDTH) (5 for 32), shift-amount width; derived, not overridden.

Ports:
- clock  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  5  operation code (see Behaviour)
- a  input  WIDTH  operand A / shift amount (a[SHW-1:0])
- b  input  WIDTH  operand B
- s  output  WIDTH  result low word (product low / quotient)
- hi  output  WIDTH  product high / remainder; 0 for single-cycle ops
- z  output  1  1 when s == 0
- v  output  1  signed overflow, ADD/SUB only; else 0
- dz  output  1  divide by zero, DIVU only; else 0
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse; s/hi/flags valid

Behaviour:
- Reset (async, resetn=0): state IDLE; s, hi, z, v, dz, busy, done = 0. Any operation in progress is dropped with no done. After release, start is accepted on the first edge.
- Opcodes with op[4]=0 are single-cycle:
  - x000 ADD: a+b; v = (a[W-1]==b[W-1]) && (s[W-1]!=a[W-1]).
  - x100 SUB: a-b; v = (a[W-1]!=b[W-1]) && (s[W-1]!=a[W-1]).
  - x001 AND; x101 OR; x010 XOR.
  - x110 LUI: b << (WIDTH/2).
  - 0011 SLL: b << a[SHW-1:0].
  - 0111 SRL: logical, zero-fill.
  - 1111 SRA: sign-fill.
  - 1011: s = 0.
- Opcodes with op[4]=1 are multicycle:
  - 10000 MULU: {hi,s} = a*b, unsigned, full 2*WIDTH product, shift-add one bit per cycle.
  - 10001 DIVU: s = a/b, hi = a%b, unsigned restoring division one bit per cycle.
  - Other 1xxxx values are illegal: complete as single-cycle with s = 0, hi = 0, all flags 0.
- States: IDLE, RUN, DONE.
  - IDLE & start & single-cycle op, at edge E: register all results and go to DONE. done=1 and busy=1 during cycle E..E+1. Back to IDLE at E+1. Latency 1.
  - IDLE & start & MULU/DIVU, at edge E: latch a, b, op; clear accumulator; iteration counter = 0; go to RUN.
  - RUN: one iteration per edge. After WIDTH iterations (edge E+WIDTH) load s/hi/flags and go to DONE. done=1 in the following cycle, then IDLE. Latency WIDTH+1.
  - start while busy (RUN or DONE) is ignored; it is not queued. a/b/op changes during RUN have no effect.
- Output holding: s, hi, z, v, dz hold their values from the last completed operation until the next completion. They do not change during RUN.
- z is computed from the final s only, for every op, including MULU (low word only) and DIVU.
- Divide by zero (b = 0): runs the full WIDTH cycles; s = all ones, hi = a, dz = 1.
- Back-to-back: start held high continuously yields one accepted operation per (latency+1) cycles, because the DONE cycle blocks acceptance.

Test Plan:
- Reset and flags (WIDTH=32): resetn low mid-RUN of MULU -> s=hi=0, done/busy=0 immediately. After release, ADD a=32'h7FFFFFFF, b=1 -> done one cycle after start, s=32'h80000000, v=1, z=0.
- Single-cycle ops: SUB a=5, b=5 -> s=0, z=1, v=0. LUI b=16'h1234 -> s=32'h12340000, hi=0.
- Shifts, b=32'h80000000, a=4: SRL -> 32'h08000000. SRA -> 32'hF8000000. SLL with a=33 uses only a[4:0], giving shift 1 -> s=0, z=1.
- MULU a=32'hFFFFFFFF, b=32'hFFFFFFFF -> busy for 33 cycles, done at cycle 33 after the start edge, hi=32'hFFFFFFFE, s=32'h00000001. A start pulse during RUN is ignored (no second done).
- DIVU a=100, b=7 -> s=14, hi=2, dz=0. DIVU a=9, b=0 -> s=32'hFFFFFFFF, hi=9, dz=1, z=0.
- Illegal op 5'b10111 -> done after 1 cycle, s=0, hi=0, z=1. Repeat all scenarios with WIDTH=8, e.g. MULU 8'hFF*8'hFF -> hi=8'hFE, s=8'h01, latency 9.

Source files
------------

// File: rtl/seq_alu_if.sv
// Operand/result bundle for seq_alu.
//   master: drives start/op/a/b, observes results (control unit / bench)
//   slave : the ALU itself
//   start  request, sampled only while idle
//   op     5-bit operation code
//   a, b   operands (a[SHW-1:0] doubles as shift amount)
//   s, hi  result low word / high word (product high or remainder)
//   z, v, dz  zero, signed overflow, divide-by-zero flags
//   busy, done  handshake status; done is a one-cycle pulse
interface seq_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] hi;
    logic             z;
    logic             v;
    logic             dz;
    logic             busy;
    logic             done;

    modport master (
        output start, op, a, b,
        input  s, hi, z, v, dz, busy, done
    );

    modport slave (
        input  start, op, a, b,
        output s, hi, z, v, dz, busy, done
    );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU for the multicycle datapath.
// Single-cycle ops (op[4]=0) complete one edge after acceptance. MULU and DIVU
// iterate one bit per edge for WIDTH edges on a shared 2*WIDTH accumulator.
// Ports:
//   clock   rising-edge clock
//   resetn  asynchronous active-low reset
//   bus     seq_alu_if slave modport (start/op/a/b in, s/hi/z/v/dz/busy/done out)
module seq_alu #(
    parameter int unsigned WIDTH = 32
) (
    input logic        clock,
    input logic        resetn,
    seq_alu_if.slave   bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e               state_q, state_d;
    // Mul: {partial high, multiplier}. Div: {remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    // Mul: multiplicand. Div: divisor.
    logic [WIDTH-1:0]     opnd_q, opnd_d;
    logic                 div_q, div_d;
    logic [SHW-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]     s_q, s_d, hi_q, hi_d;
    logic                 z_q, z_d, v_q, v_d, dz_q, dz_d;

    // ---------------- single-cycle datapath ----------------
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sum, dif, sc_s;
    logic             sc_v;

    assign sh  = bus.a[SHW-1:0];
    assign sum = bus.a + bus.b;
    assign dif = bus.a - bus.b;

    always_comb begin
        sc_s = '0;
        sc_v = 1'b0;
        unique casez (bus.op[3:0])
            4'b?000: begin
                sc_s = sum;
                sc_v = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) && (sum[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b?100: begin
                sc_s = dif;
                sc_v = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) && (dif[WIDTH-1] != bus.a[WIDTH-1]);
            end
            4'b?001: sc_s = bus.a & bus.b;
            4'b?101: sc_s = bus.a | bus.b;
            4'b?010: sc_s = bus.a ^ bus.b;
            4'b?110: sc_s = bus.b << (WIDTH / 2);
            4'b0011: sc_s = bus.b << sh;
            4'b0111: sc_s = bus.b >> sh;
            4'b1111: sc_s = WIDTH'($signed(bus.b) >>> sh);
            4'b1011: sc_s = '0;
            default: sc_s = '0;
        endcase
    end

    // ---------------- iterative step ----------------
    logic [WIDTH:0]       madd, rsh, rdif;
    logic [2*WIDTH-1:0]   mul_next, div_next, step;

    // Shift-add: add multiplicand to the high half when multiplier LSB is set,
    // then shift the whole accumulator right, keeping the carry.
    assign madd     = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                      + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH + 1){1'b0}});
    assign mul_next = {madd, acc_q[WIDTH-1:1]};

    // Restoring divide: shift next dividend bit into the remainder, trial
    // subtract, keep the difference only if it did not borrow. With a zero
    // divisor every trial succeeds, giving all-ones quotient and remainder = a.
    assign rsh      = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign rdif     = rsh - {1'b0, opnd_q};
    assign div_next = rdif[WIDTH] ? {rsh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {rdif[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    assign step     = div_q ? div_next : mul_next;

    // ---------------- control ----------------
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        opnd_d  = opnd_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        hi_d    = hi_q;
        z_d     = z_q;
        v_d     = v_q;
        dz_d    = dz_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    if (!bus.op[4]) begin
                        s_d     = sc_s;
                        hi_d    = '0;
                        z_d     = (sc_s == '0);
                        v_d     = sc_v;
                        dz_d    = 1'b0;
                        state_d = StDone;
                    end else if (bus.op[3:1] == 3'b000) begin
                        div_d   = bus.op[0];
                        opnd_d  = bus.op[0] ? bus.b : bus.a;
                        acc_d   = bus.op[0] ? {{WIDTH{1'b0}}, bus.a} : {{WIDTH{1'b0}}, bus.b};
                        cnt_d   = '0;
                        state_d = StRun;
                    end else begin
                        // Illegal multicycle code: finish at once with zeros.
                        s_d     = '0;
                        hi_d    = '0;
                        z_d     = 1'b1;
                        v_d     = 1'b0;
                        dz_d    = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StRun: begin
                acc_d = step;
                cnt_d = cnt_q + SHW'(1);
                if (cnt_q == SHW'(WIDTH - 1)) begin
                    s_d     = step[WIDTH-1:0];
                    hi_d    = step[2*WIDTH-1:WIDTH];
                    z_d     = (step[WIDTH-1:0] == '0);
                    v_d     = 1'b0;
                    dz_d    = div_q && (opnd_q == '0);
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q <= StIdle;
            acc_q   <= '0;
            opnd_q  <= '0;
            div_q   <= 1'b0;
            cnt_q   <= '0;
            s_q     <= '0;
            hi_q    <= '0;
            z_q     <= 1'b0;
            v_q     <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            opnd_q  <= opnd_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            hi_q    <= hi_d;
            z_q     <= z_d;
            v_q     <= v_d;
            dz_q    <= dz_d;
        end
    end

    assign bus.s    = s_q;
    assign bus.hi   = hi_q;
    assign bus.z    = z_q;
    assign bus.v    = v_q;
    assign bus.dz   = dz_q;
    assign bus.busy = (state_q != StIdle);
    assign bus.done = (state_q == StDone);
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: one 32-bit and one 8-bit instance on a shared
// clock/reset, expected values written out by hand.
module tb_seq_alu;
    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00001;
    localparam logic [4:0] OP_OR   = 5'b00101;
    localparam logic [4:0] OP_XOR  = 5'b00010;
    localparam logic [4:0] OP_LUI  = 5'b00110;
    localparam logic [4:0] OP_SLL  = 5'b00011;
    localparam logic [4:0] OP_SRL  = 5'b00111;
    localparam logic [4:0] OP_SRA  = 5'b01111;
    localparam logic [4:0] OP_ZRO  = 5'b01011;
    localparam logic [4:0] OP_MULU = 5'b10000;
    localparam logic [4:0] OP_DIVU = 5'b10001;
    localparam logic [4:0] OP_ILL  = 5'b10111;

    logic clock;
    logic resetn;

    seq_alu_if #(.WIDTH(32)) b32 ();
    seq_alu_if #(.WIDTH(8))  b8 ();

    seq_alu #(.WIDTH(32)) dut32 (.clock(clock), .resetn(resetn), .bus(b32));
    seq_alu #(.WIDTH(8))  dut8  (.clock(clock), .resetn(resetn), .bus(b8));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;
    int lat;
    int cnt;
    logic sel;

    // Observed outputs of the selected instance, zero-extended to 32 bits.
    logic [31:0] o_s, o_hi;
    logic        o_z, o_v, o_dz, o_busy, o_done;
    always_comb begin
        if (sel) begin
            o_s = {24'b0, b8.s};   o_hi = {24'b0, b8.hi};
            o_z = b8.z;  o_v = b8.v;  o_dz = b8.dz;  o_busy = b8.busy;  o_done = b8.done;
        end else begin
            o_s = b32.s;  o_hi = b32.hi;
            o_z = b32.z; o_v = b32.v; o_dz = b32.dz; o_busy = b32.busy; o_done = b32.done;
        end
    end

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic checki(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_start(input logic val);
        if (sel) b8.start = val;
        else     b32.start = val;
    endtask

    // Issue one operation on the selected instance; lat counts edges after
    // the accepting edge until done is seen. Then confirm done drops after one
    // cycle. With poke set, a stray request is pulsed in mid-operation.
    task automatic run(input string tag, input logic [4:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input bit poke, output int l);
        @(negedge clock);
        b32.op = o; b32.a = av; b32.b = bv;
        b8.op  = o; b8.a  = av[7:0]; b8.b = bv[7:0];
        set_start(1'b1);
        @(posedge clock); #1;
        set_start(1'b0);
        l = 0;
        while (!o_done && l < 200) begin
            if (poke && l == 3) begin
                set_start(1'b1);
                b32.op = OP_ADD; b32.a = 0; b32.b = 0;
                b8.op  = OP_ADD; b8.a  = 0; b8.b  = 0;
            end else begin
                set_start(1'b0);
            end
            @(posedge clock); #1;
            l++;
        end
        set_start(1'b0);
        check1({tag, ".busy_at_done"}, o_busy, 1'b1);
        @(posedge clock); #1;
        check1({tag, ".done_pulse"}, o_done, 1'b0);
        check1({tag, ".busy_after"}, o_busy, 1'b0);
    endtask

    initial begin
        sel = 1'b0;
        resetn = 1'b1;
        b32.start = 0; b32.op = 0; b32.a = 0; b32.b = 0;
        b8.start  = 0; b8.op  = 0; b8.a  = 0; b8.b  = 0;
        #2 resetn = 1'b0;
        #3;
        check32("rst.s", o_s, 32'h0);
        check32("rst.hi", o_hi, 32'h0);
        check1("rst.z", o_z, 1'b0);
        check1("rst.busy", o_busy, 1'b0);
        check1("rst.done", o_done, 1'b0);
        @(negedge clock) resetn = 1'b1;

        // ---------------- WIDTH = 32 ----------------
        run("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h1, 0, lat);
        checki("add_ovf.lat", lat, 0);
        check32("add_ovf.s", o_s, 32'h80000000);
        check32("add_ovf.hi", o_hi, 32'h0);
        check1("add_ovf.v", o_v, 1'b1);
        check1("add_ovf.z", o_z, 1'b0);

        run("sub_zero", OP_SUB, 32'd5, 32'd5, 0, lat);
        check32("sub_zero.s", o_s, 32'h0);
        check1("sub_zero.z", o_z, 1'b1);
        check1("sub_zero.v", o_v, 1'b0);

        run("sub_ovf", OP_SUB, 32'h80000000, 32'h1, 0, lat);
        check32("sub_ovf.s", o_s, 32'h7FFFFFFF);
        check1("sub_ovf.v", o_v, 1'b1);

        run("and", OP_AND, 32'h0000F0F0, 32'h0000FF00, 0, lat);
        check32("and.s", o_s, 32'h0000F000);
        run("or", OP_OR, 32'h0000F0F0, 32'h0000FF00, 0, lat);
        check32("or.s", o_s, 32'h0000FFF0);
        run("xor", OP_XOR, 32'h0000F0F0, 32'h0000FF00, 0, lat);
        check32("xor.s", o_s, 32'h00000FF0);

        run("lui", OP_LUI, 32'h0000FFFF, 32'h00001234, 0, lat);
        check32("lui.s", o_s, 32'h12340000);
        check32("lui.hi", o_hi, 32'h0);

        run("srl", OP_SRL, 32'd4, 32'h80000000, 0, lat);
        check32("srl.s", o_s, 32'h08000000);
        run("sra", OP_SRA, 32'd4, 32'h80000000, 0, lat);
        check32("sra.s", o_s, 32'hF8000000);
        run("sll33", OP_SLL, 32'd33, 32'h80000000, 0, lat);
        check32("sll33.s", o_s, 32'h0);
        check1("sll33.z", o_z, 1'b1);
        run("sll1", OP_SLL, 32'd33, 32'h00000003, 0, lat);
        check32("sll1.s", o_s, 32'h00000006);

        run("zro", OP_ZRO, 32'd1, 32'd1, 0, lat);
        check32("zro.s", o_s, 32'h0);

        run("mulu", OP_MULU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, lat);
        checki("mulu.lat", lat, 32);
        check32("mulu.s", o_s, 32'h00000001);
        check32("mulu.hi", o_hi, 32'hFFFFFFFE);
        check1("mulu.z", o_z, 1'b0);
        check1("mulu.dz", o_dz, 1'b0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (o_done) cnt++;
        end
        checki("mulu.no_second_done", cnt, 0);

        run("divu", OP_DIVU, 32'd100, 32'd7, 0, lat);
        checki("divu.lat", lat, 32);
        check32("divu.s", o_s, 32'd14);
        check32("divu.hi", o_hi, 32'd2);
        check1("divu.dz", o_dz, 1'b0);

        run("div0", OP_DIVU, 32'd9, 32'd0, 0, lat);
        check32("div0.s", o_s, 32'hFFFFFFFF);
        check32("div0.hi", o_hi, 32'd9);
        check1("div0.dz", o_dz, 1'b1);
        check1("div0.z", o_z, 1'b0);

        // Results hold during RUN; reset mid-RUN clears and drops the op.
        @(negedge clock);
        b32.op = OP_MULU; b32.a = 32'd2; b32.b = 32'd3; b32.start = 1'b1;
        @(posedge clock); #1;
        b32.start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check1("hold.busy", o_busy, 1'b1);
        check32("hold.s", o_s, 32'hFFFFFFFF);
        check32("hold.hi", o_hi, 32'd9);
        #3 resetn = 1'b0;
        #1;
        check32("midrst.s", o_s, 32'h0);
        check32("midrst.hi", o_hi, 32'h0);
        check1("midrst.busy", o_busy, 1'b0);
        check1("midrst.done", o_done, 1'b0);
        check1("midrst.dz", o_dz, 1'b0);
        @(negedge clock);
        resetn = 1'b1;
        b32.op = OP_ADD; b32.a = 32'h7FFFFFFF; b32.b = 32'h1; b32.start = 1'b1;
        @(posedge clock); #1;
        b32.start = 1'b0;
        check1("postrst.done", o_done, 1'b1);
        check32("postrst.s", o_s, 32'h80000000);
        check1("postrst.v", o_v, 1'b1);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clock); #1;
            if (o_done) cnt++;
        end
        checki("postrst.no_stale_done", cnt, 0);

        run("ill", OP_ILL, 32'd3, 32'd4, 0, lat);
        checki("ill.lat", lat, 0);
        check32("ill.s", o_s, 32'h0);
        check32("ill.hi", o_hi, 32'h0);
        check1("ill.z", o_z, 1'b1);

        // Start held high: accept, DONE, accept, ... -> done every other cycle.
        @(negedge clock);
        b32.op = OP_ADD; b32.a = 32'd1; b32.b = 32'd1; b32.start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clock); #1;
            if (o_done) cnt++;
        end
        b32.start = 1'b0;
        checki("b2b.dones", cnt, 4);
        check32("b2b.s", o_s, 32'd2);
        @(posedge clock); #1;

        // ---------------- WIDTH = 8 ----------------
        sel = 1'b1;
        #0;
        run("w8.add", OP_ADD, 32'h7F, 32'h01, 0, lat);
        checki("w8.add.lat", lat, 0);
        check32("w8.add.s", o_s, 32'h80);
        check1("w8.add.v", o_v, 1'b1);
        run("w8.sra", OP_SRA, 32'd4, 32'h80, 0, lat);
        check32("w8.sra.s", o_s, 32'hF8);
        run("w8.lui", OP_LUI, 32'd0, 32'h12, 0, lat);
        check32("w8.lui.s", o_s, 32'h20);
        run("w8.sll", OP_SLL, 32'd33, 32'h80, 0, lat);
        check1("w8.sll.z", o_z, 1'b1);
        run("w8.mulu", OP_MULU, 32'hFF, 32'hFF, 1, lat);
        checki("w8.mulu.lat", lat, 8);
        check32("w8.mulu.s", o_s, 32'h01);
        check32("w8.mulu.hi", o_hi, 32'hFE);
        run("w8.divu", OP_DIVU, 32'd100, 32'd7, 0, lat);
        checki("w8.divu.lat", lat, 8);
        check32("w8.divu.s", o_s, 32'h0E);
        check32("w8.divu.hi", o_hi, 32'h02);
        run("w8.div0", OP_DIVU, 32'd9, 32'd0, 0, lat);
        check32("w8.div0.s", o_s, 32'hFF);
        check32("w8.div0.hi", o_hi, 32'h09);
        check1("w8.div0.dz", o_dz, 1'b1);
        run("w8.ill", OP_ILL, 32'd3, 32'd4, 0, lat);
        checki("w8.ill.lat", lat, 0);
        check32("w8.ill.s", o_s, 32'h0);
        check1("w8.ill.z", o_z, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
